// File: rtl/dht11_sensor_responder_pkg.sv
`timescale 1ns/1ps
// Shared types, default timing and frame assembly for the DHT11 sensor responder.
package dht11_sensor_responder_pkg;

    localparam int FRAME_BITS       = 40;
    localparam int DEF_CLK_MHZ      = 100;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_TURN_US      = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 26;
    localparam int DEF_BIT1_HIGH_US = 70;
    localparam int DEF_HOLDOFF_US   = 1000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MEAS_LOW,
        ST_TURN,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW,
        ST_HOLDOFF
    } resp_state_e;

    // Frame is sent MSB first: humid_int, humid_dec, temp_int, temp_dec, checksum.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] hi, input logic [7:0] hd,
                                                          input logic [7:0] ti, input logic [7:0] td,
                                                          input logic corrupt);
        logic [7:0] cs;
        cs = hi + hd + ti + td;
        cs = cs ^ {7'd0, corrupt};
        return {hi, hd, ti, td, cs};
    endfunction

endpackage

// File: rtl/dht11_sensor_responder_if.sv
`timescale 1ns/1ps
// Data bytes in and status pulses out of the DHT11 responder; the bus wire stays a top-level port.
interface dht11_sensor_responder_if;
    logic [7:0] humid_int;
    logic [7:0] humid_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       corrupt_cs;
    logic       busy;
    logic       frame_done;
    logic       start_err;
    logic       bus_err;

    modport master (output humid_int, humid_dec, temp_int, temp_dec, corrupt_cs,
                    input  busy, frame_done, start_err, bus_err);
    modport slave  (input  humid_int, humid_dec, temp_int, temp_dec, corrupt_cs,
                    output busy, frame_done, start_err, bus_err);
endinterface

// File: rtl/dht11_sensor_responder_us_tick_gen.sv
`timescale 1ns/1ps
// Divides clk by CLK_MHZ into a one-cycle tick every microsecond.
module dht11_sensor_responder_us_tick_gen #(
    parameter int CLK_MHZ = 100
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);
    localparam int           W        = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(CLK_MHZ - 1);

    logic [W-1:0] div_q, div_d;
    logic         tick_q, tick_d;

    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/dht11_sensor_responder.sv
`timescale 1ns/1ps
// DHT11 sensor emulator: waits for a host start pulse on the open-drain line and answers
// with the response preamble and a 40-bit humidity/temperature frame.
module dht11_sensor_responder
    import dht11_sensor_responder_pkg::*;
#(
    parameter int CLK_MHZ      = DEF_CLK_MHZ,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int TURN_US      = DEF_TURN_US,
    parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DEF_BIT1_HIGH_US,
    parameter int HOLDOFF_US   = DEF_HOLDOFF_US
) (
    input  logic clk,
    input  logic reset_p,
    inout  wire  dht11_data,
    dht11_sensor_responder_if.slave sif
);
    localparam logic [15:0] START_MIN      = 16'(START_MIN_US);
    localparam logic [15:0] TURN_LAST      = 16'(TURN_US - 1);
    localparam logic [15:0] RESP_LOW_LAST  = 16'(RESP_LOW_US - 1);
    localparam logic [15:0] RESP_HIGH_LAST = 16'(RESP_HIGH_US - 1);
    localparam logic [15:0] BIT_LOW_LAST   = 16'(BIT_LOW_US - 1);
    localparam logic [15:0] BIT0_LAST      = 16'(BIT0_HIGH_US - 1);
    localparam logic [15:0] BIT1_LAST      = 16'(BIT1_HIGH_US - 1);
    localparam logic [15:0] HOLDOFF_LAST   = 16'(HOLDOFF_US - 1);
    localparam logic [5:0]  NBITS          = 6'(FRAME_BITS);

    logic tick;

    dht11_sensor_responder_us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    resp_state_e           state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]            settle_q, settle_d;
    logic                  sync0_q, sync1_q, line_prev_q;
    logic                  drive_low_q, drive_low_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  start_err_q, start_err_d;
    logic                  bus_err_q, bus_err_d;
    logic [15:0]           last;
    logic                  phase_done, line_fell, released_low;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        settle_d     = settle_q;
        frame_done_d = 1'b0;
        start_err_d  = 1'b0;
        bus_err_d    = 1'b0;

        if (tick && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (settle_q != 2'd2) settle_d = settle_q + 2'd1;

        last = '0;
        case (state_q)
            ST_TURN:      last = TURN_LAST;
            ST_RESP_LOW:  last = RESP_LOW_LAST;
            ST_RESP_HIGH: last = RESP_HIGH_LAST;
            ST_BIT_LOW:   last = BIT_LOW_LAST;
            ST_BIT_HIGH:  last = shreg_q[FRAME_BITS-1] ? BIT1_LAST : BIT0_LAST;
            ST_END_LOW:   last = BIT_LOW_LAST;
            ST_HOLDOFF:   last = HOLDOFF_LAST;
            default:      last = '0;
        endcase

        phase_done   = tick && (cnt_q == last);
        line_fell    = line_prev_q && !sync1_q;
        // The synced line lags our own release by two cycles, so low is only trusted after that.
        released_low = (settle_q == 2'd2) && !sync1_q;

        case (state_q)
            ST_IDLE: if (line_fell) state_d = ST_MEAS_LOW;
            ST_MEAS_LOW:
                if (sync1_q) begin
                    if (cnt_q >= START_MIN) begin
                        state_d = ST_TURN;
                    end else begin
                        start_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            ST_TURN:
                if (!sync1_q) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (phase_done) begin
                    shreg_d   = build_frame(sif.humid_int, sif.humid_dec, sif.temp_int,
                                            sif.temp_dec, sif.corrupt_cs);
                    bit_cnt_d = NBITS;
                    state_d   = ST_RESP_LOW;
                end
            ST_RESP_LOW: if (phase_done) state_d = ST_RESP_HIGH;
            ST_RESP_HIGH:
                if (released_low) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (phase_done) begin
                    state_d = ST_BIT_LOW;
                end
            ST_BIT_LOW: if (phase_done) state_d = ST_BIT_HIGH;
            ST_BIT_HIGH:
                if (released_low) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (phase_done) begin
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 6'd1;
                    state_d   = (bit_cnt_q == 6'd1) ? ST_END_LOW : ST_BIT_LOW;
                end
            ST_END_LOW:
                if (phase_done) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_HOLDOFF;
                end
            ST_HOLDOFF: if (phase_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d    = '0;
            settle_d = '0;
        end

        drive_low_d = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_MEAS_LOW);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            settle_q     <= '0;
            sync0_q      <= 1'b1;
            sync1_q      <= 1'b1;
            line_prev_q  <= 1'b1;
            drive_low_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_q     <= settle_d;
            sync0_q      <= dht11_data;
            sync1_q      <= sync0_q;
            line_prev_q  <= sync1_q;
            drive_low_q  <= drive_low_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            start_err_q  <= start_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dht11_data     = drive_low_q ? 1'b0 : 1'bz;
    assign sif.busy       = busy_q;
    assign sif.frame_done = frame_done_q;
    assign sif.start_err  = start_err_q;
    assign sif.bus_err    = bus_err_q;
endmodule
